mux_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one 2:1 data mux between two requesters (A, B).
- Grants one requester at a time and drives the mux select.
- Registers the selected data onto a single output channel.
- Caps grant tenure at MAX_HOLD beats when both requesters are active, so neither side can starve the other.
- Sits between two producer blocks and a single downstream consumer.

---
 rtl/mux_rr_arbiter_pkg.sv | 28 ++
 rtl/mux_rr_arbiter_hold.sv | 46 ++++
 rtl/mux_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
// Holds the FSM state type, the side constants and small helpers.
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // Grant state that corresponds to a given side.
    function automatic arb_state_e side_state(input logic side);
        if (side == SIDE_B) begin
            return GNT_B;
        end else begin
            return GNT_A;
        end
    endfunction

    // Opposite side, used for tie-breaks and rotation.
    function automatic logic other_side(input logic side);
        return ~side;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_hold.sv
// Tenure counter for the current grant owner.
// Saturates at MAX_HOLD-1; at_max is registered alongside the count.
module arb_hold_counter #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);
    localparam logic AT_MAX_RST = (MAX_HOLD == 1) ? 1'b1 : 1'b0;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          at_max_r;

    // Next count: clear wins, increment never passes LIMIT.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = '0;
        end else if (inc && (cnt_r != LIMIT)) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register and its registered limit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            at_max_r <= AT_MAX_RST;
        end else begin
            cnt_r    <= cnt_next_s;
            at_max_r <= (cnt_next_s == LIMIT);
        end
    end

    assign at_max = at_max_r;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 2:1 data mux between requesters A and B,
// with bounded tenure under contention and a registered output channel.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    arb_state_e       state_r;
    arb_state_e       state_next_s;
    logic             last_r;
    logic             last_next_s;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;

    logic             hold_clr_s;
    logic             hold_inc_s;
    logic             hold_at_max_s;
    logic             cur_side_s;
    logic             own_req_s;
    logic             oth_req_s;
    logic             beat_s;

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (hold_clr_s),
        .inc    (hold_inc_s),
        .at_max (hold_at_max_s)
    );

    // Owner's view of the requests and the beat qualifier.
    always_comb begin
        cur_side_s = (state_r == GNT_B) ? SIDE_B : SIDE_A;
        own_req_s  = (cur_side_s == SIDE_B) ? req_b : req_a;
        oth_req_s  = (cur_side_s == SIDE_B) ? req_a : req_b;
        beat_s     = (gnt_a_r & req_a) | (gnt_b_r & req_b);
    end

    // Next-state, last-served side and tenure counter control.
    always_comb begin
        state_next_s = state_r;
        last_next_s  = last_r;
        hold_clr_s   = 1'b0;
        hold_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                hold_clr_s = 1'b1;
                if (req_a && req_b) begin
                    state_next_s = side_state(other_side(last_r));
                end else if (req_a) begin
                    state_next_s = GNT_A;
                end else if (req_b) begin
                    state_next_s = GNT_B;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT_A, GNT_B: begin
                if (!own_req_s) begin
                    hold_clr_s  = 1'b1;
                    last_next_s = cur_side_s;
                    if (oth_req_s) begin
                        state_next_s = side_state(other_side(cur_side_s));
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (oth_req_s) begin
                    if (hold_at_max_s) begin
                        // Forced rotation: the owner has used its full tenure.
                        hold_clr_s   = 1'b1;
                        last_next_s  = cur_side_s;
                        state_next_s = side_state(other_side(cur_side_s));
                    end else begin
                        hold_inc_s = 1'b1;
                    end
                end else begin
                    hold_clr_s = 1'b1;
                end
            end
            default: begin
                hold_clr_s   = 1'b1;
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state and last-served side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            last_r  <= SIDE_B;
        end else begin
            state_r <= state_next_s;
            last_r  <= last_next_s;
        end
    end

    // Registered grants and output channel; data only moves on beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            gnt_a_r     <= (state_next_s == GNT_A);
            gnt_b_r     <= (state_next_s == GNT_B);
            out_valid_r <= beat_s;
            if (beat_s) begin
                out_data_r <= gnt_b_r ? data_b : data_a;
            end
        end
    end

    assign gnt_a     = gnt_a_r;
    assign gnt_b     = gnt_b_r;
    assign sel       = gnt_b_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table for the steady-state
// arbitration sequences plus hand sequences for reset and MAX_HOLD=1.
module tb_mux_rr_arbiter;

    typedef struct {
        logic       ra;
        logic [7:0] da;
        logic       rb;
        logic [7:0] db;
        logic       ga;
        logic       gb;
        logic       ov;
        logic [7:0] od;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic       gnt_a, gnt_b, sel, out_valid;
    logic [7:0] out_data;

    logic       req_a1, req_b1;
    logic [7:0] data_a1, data_b1;
    logic       gnt_a1, gnt_b1, sel1, out_valid1;
    logic [7:0] out_data1;

    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    mux_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .out_data(out_data), .out_valid(out_valid)
    );

    mux_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a1), .data_a(data_a1), .req_b(req_b1), .data_b(data_b1),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1),
        .out_data(out_data1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ra, input logic [7:0] da, input logic rb, input logic [7:0] db,
                       input logic ga, input logic gb, input logic ov, input logic [7:0] od);
        vec_t v;
        v.ra = ra; v.da = da; v.rb = rb; v.db = db;
        v.ga = ga; v.gb = gb; v.ov = ov; v.od = od;
        vecs.push_back(v);
    endtask

    // Compares {gnt_a, gnt_b, sel, out_valid, out_data}.
    task automatic cmp(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got ga=%b gb=%b sel=%b ov=%b od=%h, want ga=%b gb=%b sel=%b ov=%b od=%h",
                     nm, idx, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        req_a1 = 1'b0; req_b1 = 1'b0; data_a1 = 8'hAA; data_b1 = 8'h55;

        // Contention from reset: A first, then A x4, B x4, A x4.
        add(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 8'h00);
        add(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 8'hA0);
        add(1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 8'hA1);
        add(1'b1, 8'hA2, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 8'hA2);
        add(1'b1, 8'hA3, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hA3);
        add(1'b1, 8'hA4, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hB0);
        add(1'b1, 8'hA4, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB1);
        add(1'b1, 8'hA4, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hB2);
        add(1'b1, 8'hA4, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 8'hB3);
        add(1'b1, 8'hA4, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 8'hA4);
        add(1'b1, 8'hA5, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 8'hA5);
        add(1'b1, 8'hA6, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 8'hA6);
        add(1'b1, 8'hA7, 1'b1, 8'hB4, 1'b0, 1'b1, 1'b1, 8'hA7);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA7);
        // Single requester A, ten beats, no rotation.
        add(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA7);
        for (int i = 0; i < 10; i++) begin
            add(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10 + 8'(i));
        end
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h19);
        // Tie after idle with A served last: B wins.
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h19);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h19);
        add(1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 8'h19);
        add(1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 8'h30);
        add(1'b1, 8'h20, 1'b1, 8'h31, 1'b0, 1'b1, 1'b1, 8'h31);
        add(1'b1, 8'h20, 1'b1, 8'h32, 1'b0, 1'b1, 1'b1, 8'h32);
        add(1'b1, 8'h20, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33);
        add(1'b1, 8'h20, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 8'h20);
        add(1'b1, 8'h21, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 8'h21);
        // Early release by A after 2 beats: direct handover, fresh B tenure.
        add(1'b0, 8'h22, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 8'h21);
        add(1'b1, 8'h22, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 8'h34);
        add(1'b1, 8'h22, 1'b1, 8'h35, 1'b0, 1'b1, 1'b1, 8'h35);
        add(1'b1, 8'h22, 1'b1, 8'h36, 1'b0, 1'b1, 1'b1, 8'h36);
        add(1'b1, 8'h22, 1'b1, 8'h37, 1'b1, 1'b0, 1'b1, 8'h37);
        add(1'b1, 8'h22, 1'b1, 8'h38, 1'b1, 1'b0, 1'b1, 8'h22);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22);

        #12;
        cmp("reset", 0, {gnt_a, gnt_b, sel, out_valid, out_data}, 12'h000);
        cmp("reset_mh1", 0, {gnt_a1, gnt_b1, sel1, out_valid1, out_data1}, 12'h000);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db;
            tick();
            cmp("vec", i, {gnt_a, gnt_b, sel, out_valid, out_data},
                {vecs[i].ga, vecs[i].gb, vecs[i].gb, vecs[i].ov, vecs[i].od});
        end

        // Reset in the middle of an A tenure, between clock edges.
        req_a = 1'b1; data_a = 8'hC0; req_b = 1'b0;
        tick();
        tick();
        data_a = 8'hC1;
        tick();
        cmp("pre_reset", 0, {gnt_a, gnt_b, sel, out_valid, out_data}, {4'b1001, 8'hC1});
        #2 rst_n = 1'b0;
        #1;
        cmp("async_reset", 0, {gnt_a, gnt_b, sel, out_valid, out_data}, 12'h000);
        req_a = 1'b0; req_b = 1'b1;
        rst_n = 1'b1;
        tick();
        cmp("post_reset_b", 0, {gnt_a, gnt_b, sel, out_valid, out_data}, {4'b0110, 8'h00});
        req_b = 1'b0;
        tick();
        cmp("post_reset_idle", 0, {gnt_a, gnt_b, sel, out_valid, out_data}, 12'h000);

        // MAX_HOLD=1: strict alternation under contention.
        req_a1 = 1'b1; req_b1 = 1'b1;
        tick();
        cmp("mh1_first", 0, {gnt_a1, gnt_b1, sel1, out_valid1, out_data1}, {4'b1000, 8'h00});
        for (int k = 0; k < 6; k++) begin
            tick();
            if ((k % 2) == 0) begin
                cmp("mh1_alt", k, {gnt_a1, gnt_b1, sel1, out_valid1, out_data1}, {4'b0111, 8'hAA});
            end else begin
                cmp("mh1_alt", k, {gnt_a1, gnt_b1, sel1, out_valid1, out_data1}, {4'b1001, 8'h55});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
